// File: rtl/tl_scratchpad_pkg.sv
// Shared definitions for the TileLink-UH scratchpad: bus encodings, FSM states
// and the byte-lane select / extract / place helpers.
package tl_scratchpad_pkg;

  // A-channel opcodes
  localparam logic [2:0] TL_PUT_F           = 3'd0;
  localparam logic [2:0] TL_ARITH_DATA      = 3'd2;
  localparam logic [2:0] TL_LOGIC_DATA      = 3'd3;
  localparam logic [2:0] TL_GET             = 3'd4;
  // D-channel opcodes
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  localparam logic [2:0] AMO_MIN  = 3'd0;
  localparam logic [2:0] AMO_MAX  = 3'd1;
  localparam logic [2:0] AMO_MINU = 3'd2;
  localparam logic [2:0] AMO_MAXU = 3'd3;
  localparam logic [2:0] AMO_ADD  = 3'd4;
  localparam logic [2:0] AMO_XOR  = 3'd0;
  localparam logic [2:0] AMO_OR   = 3'd1;
  localparam logic [2:0] AMO_AND  = 3'd2;
  localparam logic [2:0] AMO_SWAP = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_MODIFY = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Misaligned offsets snap down to the naturally aligned container.
  function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
    logic [2:0] r;
    case (size)
      2'd0:    r = off;
      2'd1:    r = {off[2:1], 1'b0};
      2'd2:    r = {off[2], 2'b00};
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      2'd0:    m = 64'h0000_0000_0000_00ff;
      2'd1:    m = 64'h0000_0000_0000_ffff;
      2'd2:    m = 64'h0000_0000_ffff_ffff;
      default: m = 64'hffff_ffff_ffff_ffff;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << align_off(size, off);
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] word, input logic [1:0] size,
                                          input logic [2:0] off);
    return (word >> {align_off(size, off), 3'b000}) & size_mask(size);
  endfunction

  function automatic logic [63:0] place(input logic [63:0] data, input logic [1:0] size,
                                        input logic [2:0] off);
    return (data & size_mask(size)) << {align_off(size, off), 3'b000};
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] val, input logic [1:0] size);
    logic [63:0] r;
    case (size)
      2'd0:    r = {{56{val[7]}}, val[7:0]};
      2'd1:    r = {{48{val[15]}}, val[15:0]};
      2'd2:    r = {{32{val[31]}}, val[31:0]};
      default: r = val;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tilelink.sv
// TileLink-UH single-beat A/D channel bundle shared by masters and responders.
interface tilelink;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [3:0]  a_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [3:0]  d_source;
  logic [63:0] d_data;

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_data
  );

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_data
  );
endinterface

// File: rtl/tl_scratchpad_amo.sv
// Combinational AMO ALU: computes the write-back value from the old memory value
// and the operand, both LSB-justified and evaluated at the access size.
module tl_amo_alu
  import tl_scratchpad_pkg::*;
(
  input  logic [2:0]  opcode_i,
  input  logic [2:0]  param_i,
  input  logic [1:0]  size_i,
  input  logic [63:0] old_i,
  input  logic [63:0] operand_i,
  output logic [63:0] new_o
);
  logic [63:0] mask_s;
  logic [63:0] a_s;
  logic [63:0] b_s;
  logic [63:0] sum_s;
  logic        lt_s;
  logic        ltu_s;

  assign mask_s = size_mask(size_i);
  assign a_s    = old_i & mask_s;
  assign b_s    = operand_i & mask_s;
  assign sum_s  = (a_s + b_s) & mask_s;
  assign lt_s   = $signed(sext(a_s, size_i)) < $signed(sext(b_s, size_i));
  assign ltu_s  = a_s < b_s;

  always_comb begin
    new_o = a_s;
    case (opcode_i)
      TL_ARITH_DATA: begin
        case (param_i)
          AMO_MIN:  new_o = lt_s  ? a_s : b_s;
          AMO_MAX:  new_o = lt_s  ? b_s : a_s;
          AMO_MINU: new_o = ltu_s ? a_s : b_s;
          AMO_MAXU: new_o = ltu_s ? b_s : a_s;
          AMO_ADD:  new_o = sum_s;
          default:  new_o = a_s;
        endcase
      end
      TL_LOGIC_DATA: begin
        case (param_i)
          AMO_XOR:  new_o = a_s ^ b_s;
          AMO_OR:   new_o = a_s | b_s;
          AMO_AND:  new_o = a_s & b_s;
          AMO_SWAP: new_o = b_s;
          default:  new_o = a_s;
        endcase
      end
      default: new_o = a_s;
    endcase
  end
endmodule

// File: rtl/tl_scratchpad.sv
// TileLink-UH scratchpad responder: one request at a time against a private
// 64-bit-wide single-port array, one D beat per request.
module tl_scratchpad
  import tl_scratchpad_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input logic   clk,
  input logic   rst_n,
  tilelink.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 3;

  state_e          state_q, state_d;
  logic            a_ready_q, a_ready_d;
  logic            d_valid_q, d_valid_d;
  logic [2:0]      d_opcode_q, d_opcode_d;
  logic [1:0]      d_size_q, d_size_d;
  logic [3:0]      d_source_q, d_source_d;
  logic [63:0]     d_data_q, d_data_d;

  logic [2:0]      cap_opcode_q, cap_param_q;
  logic [1:0]      cap_size_q;
  logic [3:0]      cap_source_q;
  logic [IW-1:0]   cap_idx_q;
  logic [2:0]      cap_off_q;
  logic [63:0]     cap_data_q;
  logic            cap_en;

  logic [63:0]     mem [DEPTH];
  logic [63:0]     rdata_q;
  logic            mem_we, mem_re;
  logic [IW-1:0]   mem_idx;
  logic [63:0]     mem_wdata;
  logic [7:0]      mem_lanes;

  logic            accept;
  logic [2:0]      a_op_norm;
  logic [IW-1:0]   a_idx;
  logic [2:0]      a_off;
  logic [63:0]     old_val;
  logic [63:0]     alu_new;
  logic            unused;

  assign accept  = bus.a_valid && a_ready_q;
  assign a_idx   = bus.a_address[OW-1:3];
  assign a_off   = bus.a_address[2:0];
  assign old_val = extract(rdata_q, cap_size_q, cap_off_q);
  assign unused  = ^{bus.a_mask, bus.a_address[63:OW]};

  // Unknown opcodes are serviced as Get.
  always_comb begin
    case (bus.a_opcode)
      TL_PUT_F, TL_ARITH_DATA, TL_LOGIC_DATA: a_op_norm = bus.a_opcode;
      default:                                a_op_norm = TL_GET;
    endcase
  end

  tl_amo_alu u_alu (
    .opcode_i  (cap_opcode_q),
    .param_i   (cap_param_q),
    .size_i    (cap_size_q),
    .old_i     (old_val),
    .operand_i (cap_data_q),
    .new_o     (alu_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (a_op_norm == TL_PUT_F) ? ST_RESP : ST_READ;
        else        state_d = ST_IDLE;
      end
      ST_READ:   state_d = (cap_opcode_q == TL_GET) ? ST_RESP : ST_MODIFY;
      ST_MODIFY: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.d_ready) state_d = ST_IDLE;
        else             state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // AMO write-back happens only in MODIFY, so an abort leaves memory all-old or all-new.
  always_comb begin
    a_ready_d  = (state_d == ST_IDLE);
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    cap_en     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_idx    = cap_idx_q;
    mem_wdata  = place(alu_new, cap_size_q, cap_off_q);
    mem_lanes  = lane_mask(cap_size_q, cap_off_q);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cap_en  = 1'b1;
          mem_idx = a_idx;
          if (a_op_norm == TL_PUT_F) begin
            mem_we     = 1'b1;
            mem_wdata  = place(bus.a_data, bus.a_size, a_off);
            mem_lanes  = lane_mask(bus.a_size, a_off);
            d_valid_d  = 1'b1;
            d_opcode_d = TL_ACCESS_ACK;
            d_size_d   = bus.a_size;
            d_source_d = bus.a_source;
            d_data_d   = 64'd0;
          end else begin
            mem_re = 1'b1;
          end
        end else begin
          mem_idx = cap_idx_q;
        end
      end
      ST_READ: begin
        if (cap_opcode_q == TL_GET) begin
          d_valid_d  = 1'b1;
          d_opcode_d = TL_ACCESS_ACK_DATA;
          d_size_d   = cap_size_q;
          d_source_d = cap_source_q;
          d_data_d   = old_val;
        end else begin
          d_valid_d = 1'b0;
        end
      end
      ST_MODIFY: begin
        mem_we     = 1'b1;
        d_valid_d  = 1'b1;
        d_opcode_d = TL_ACCESS_ACK_DATA;
        d_size_d   = cap_size_q;
        d_source_d = cap_source_q;
        d_data_d   = old_val;
      end
      ST_RESP: begin
        if (bus.d_ready) d_valid_d = 1'b0;
        else             d_valid_d = 1'b1;
      end
      default: d_valid_d = 1'b0;
    endcase
  end

  // Registered handshake and D-channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ready_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= 3'd0;
      d_size_q   <= 2'd0;
      d_source_q <= 4'd0;
      d_data_q   <= 64'd0;
    end else begin
      a_ready_q  <= a_ready_d;
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_opcode_q <= 3'd0;
      cap_param_q  <= 3'd0;
      cap_size_q   <= 2'd0;
      cap_source_q <= 4'd0;
      cap_idx_q    <= '0;
      cap_off_q    <= 3'd0;
      cap_data_q   <= 64'd0;
    end else if (cap_en) begin
      cap_opcode_q <= a_op_norm;
      cap_param_q  <= bus.a_param;
      cap_size_q   <= bus.a_size;
      cap_source_q <= bus.a_source;
      cap_idx_q    <= a_idx;
      cap_off_q    <= a_off;
      cap_data_q   <= bus.a_data;
    end
  end

  // Single-port array with per-byte write enables; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_lanes[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_re) rdata_q <= mem[mem_idx];
  end

  assign bus.a_ready  = a_ready_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.d_opcode = d_opcode_q;
  assign bus.d_size   = d_size_q;
  assign bus.d_source = d_source_q;
  assign bus.d_data   = d_data_q;
endmodule

// File: tb/tb_tl_scratchpad.sv
// Directed bench for tl_scratchpad: hand-computed responses, latencies,
// back-pressure and mid-AMO reset behaviour.
module tb_tl_scratchpad;
  localparam logic [2:0] PUT = 3'd0, ARITH = 3'd2, LOGIC = 3'd3, GET = 3'd4;
  localparam logic [2:0] ACK = 3'd0, ACKD = 3'd1;

  logic clk;
  logic rst_n;
  tilelink tl ();

  tl_scratchpad #(.DEPTH(512)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tl)
  );

  int          checks   = 0;
  int          failures = 0;
  int          lat;
  logic [63:0] rd;
  logic [2:0]  rop;
  logic [1:0]  rsz;
  logic [3:0]  rsrc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble_a();
    tl.a_valid   = 1'b0;
    tl.a_opcode  = PUT;
    tl.a_param   = 3'd7;
    tl.a_size    = 2'd3;
    tl.a_source  = 4'hf;
    tl.a_address = 64'h0;
    tl.a_data    = 64'hffff_ffff_ffff_ffff;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] prm, input logic [1:0] sz,
                      input logic [3:0] src, input logic [63:0] addr, input logic [63:0] data);
    bit acc;
    acc          = 1'b0;
    tl.a_opcode  = op;
    tl.a_param   = prm;
    tl.a_size    = sz;
    tl.a_source  = src;
    tl.a_address = addr;
    tl.a_mask    = 8'h00;
    tl.a_data    = data;
    tl.a_valid   = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (tl.a_ready === 1'b1) begin
        @(posedge clk);
        acc = 1'b1;
      end
    end
    #1;
    scramble_a();
    check("accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic wait_d();
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (tl.d_valid === 1'b1) got = 1'b1;
    end
    check("d_valid_timeout", {63'd0, got}, 64'd1);
    rd   = tl.d_data;
    rop  = tl.d_opcode;
    rsz  = tl.d_size;
    rsrc = tl.d_source;
  endtask

  task automatic finish_d();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] prm, input logic [1:0] sz,
                     input logic [63:0] addr, input logic [63:0] data);
    send(op, prm, sz, 4'h5, addr, data);
    wait_d();
    finish_d();
  endtask

  initial begin
    rst_n      = 1'b1;
    tl.d_ready = 1'b1;
    tl.a_mask  = 8'h00;
    scramble_a();
    #2 rst_n = 1'b0;
    #10;
    check("rst_a_ready",  {63'd0, tl.a_ready}, 64'd0);
    check("rst_d_valid",  {63'd0, tl.d_valid}, 64'd0);
    check("rst_d_opcode", {61'd0, tl.d_opcode}, 64'd0);
    check("rst_d_size",   {62'd0, tl.d_size}, 64'd0);
    check("rst_d_source", {60'd0, tl.d_source}, 64'd0);
    check("rst_d_data",   tl.d_data, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_a_ready", {63'd0, tl.a_ready}, 64'd1);

    // Full-word put then get
    req(PUT, 3'd0, 2'd3, 64'h400, 64'h0706050403020100);
    check("put8_lat", 64'(lat), 64'd1);
    check("put8_op", {61'd0, rop}, {61'd0, ACK});
    check("put8_data", rd, 64'd0);
    req(GET, 3'd0, 2'd3, 64'h400, 64'd0);
    check("get8_lat", 64'(lat), 64'd2);
    check("get8_op", {61'd0, rop}, {61'd0, ACKD});
    check("get8_data", rd, 64'h0706050403020100);
    check("get8_src", {60'd0, rsrc}, 64'h5);

    // Byte puts with junk above the size
    for (int i = 0; i < 8; i++) begin
      req(PUT, 3'd0, 2'd0, 64'h418 + 64'(i), 64'hcafef00d12345600 | (64'h00000000000000a8 + 64'(i)));
      check("putb_lat", 64'(lat), 64'd1);
    end
    req(GET, 3'd0, 2'd3, 64'h418, 64'd0);
    check("getb8", rd, 64'hafaeadacabaaa9a8);
    req(GET, 3'd0, 2'd1, 64'h41a, 64'd0);
    check("get2", rd, 64'h000000000000abaa);
    check("get2_size", {62'd0, rsz}, 64'd1);
    req(GET, 3'd0, 2'd0, 64'h41d, 64'd0);
    check("get1", rd, 64'h00000000000000ad);
    req(GET, 3'd0, 2'd1, 64'h41b, 64'd0);
    check("get2_misaligned", rd, 64'h000000000000abaa);
    req(GET, 3'd0, 2'd3, 64'h1418, 64'd0);
    check("get8_wrap", rd, 64'hafaeadacabaaa9a8);
    req(3'd6, 3'd0, 2'd0, 64'h41e, 64'd0);
    check("unknown_op_as_get", rd, 64'h00000000000000ae);

    // 64-bit ADD
    req(ARITH, 3'd4, 2'd3, 64'h400, 64'd1);
    check("add_lat", 64'(lat), 64'd3);
    check("add_op", {61'd0, rop}, {61'd0, ACKD});
    check("add_old", rd, 64'h0706050403020100);
    req(GET, 3'd0, 2'd3, 64'h400, 64'd0);
    check("add_new", rd, 64'h0706050403020101);

    // 32-bit signed / unsigned MIN
    req(PUT, 3'd0, 2'd3, 64'h408, 64'h1122334400000005);
    req(ARITH, 3'd0, 2'd2, 64'h408, 64'h00000000ffffffff);
    check("min_old", rd, 64'd5);
    req(GET, 3'd0, 2'd3, 64'h408, 64'd0);
    check("min_new", rd, 64'h11223344ffffffff);
    req(PUT, 3'd0, 2'd2, 64'h408, 64'd5);
    req(ARITH, 3'd2, 2'd2, 64'h408, 64'h00000000ffffffff);
    check("minu_old", rd, 64'd5);
    req(GET, 3'd0, 2'd3, 64'h408, 64'd0);
    check("minu_new", rd, 64'h1122334400000005);

    // 16-bit XOR on the upper half of the word
    req(LOGIC, 3'd0, 2'd1, 64'h40c, 64'h00000000000000ff);
    check("xor_old", rd, 64'h0000000000003344);
    req(GET, 3'd0, 2'd3, 64'h408, 64'd0);
    check("xor_new", rd, 64'h112233bb00000005);

    // D back-pressure while a second request waits
    tl.d_ready = 1'b0;
    send(GET, 3'd0, 2'd3, 4'h3, 64'h400, 64'd0);
    wait_d();
    check("stall_lat", 64'(lat), 64'd2);
    check("stall_data0", rd, 64'h0706050403020101);
    tl.a_opcode  = GET;
    tl.a_size    = 2'd3;
    tl.a_source  = 4'h9;
    tl.a_address = 64'h418;
    tl.a_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_d_valid", {63'd0, tl.d_valid}, 64'd1);
      check("stall_d_data", tl.d_data, 64'h0706050403020101);
      check("stall_d_source", {60'd0, tl.d_source}, 64'h3);
      check("stall_a_ready", {63'd0, tl.a_ready}, 64'd0);
    end
    tl.d_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after_hs_a_ready", {63'd0, tl.a_ready}, 64'd1);
    check("after_hs_d_valid", {63'd0, tl.d_valid}, 64'd0);
    @(posedge clk);
    #1;
    scramble_a();
    wait_d();
    check("second_lat", 64'(lat), 64'd2);
    check("second_data", rd, 64'hafaeadacabaaa9a8);
    check("second_src", {60'd0, rsrc}, 64'h9);
    finish_d();

    // Reset during AMO READ
    send(ARITH, 3'd4, 2'd3, 4'h1, 64'h400, 64'd5);
    rst_n = 1'b0;
    #1;
    check("amo_rst_d_valid", {63'd0, tl.d_valid}, 64'd0);
    check("amo_rst_a_ready", {63'd0, tl.a_ready}, 64'd0);
    repeat (3) @(negedge clk);
    check("amo_rst_hold_d_valid", {63'd0, tl.d_valid}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("amo_rst_rel_a_ready", {63'd0, tl.a_ready}, 64'd1);
    req(GET, 3'd0, 2'd3, 64'h400, 64'd0);
    check("amo_rst_mem", rd, 64'h0706050403020101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tl_scratchpad.md
# tl_scratchpad

TileLink-UH responder that owns a private 64-bit-wide on-chip SRAM and services Get, PutFullData, ArithmeticData and LogicalData requests from one bus master. It is the slave end of the same `tilelink` interface the core and test masters drive. It is used as boot scratchpad and AMO test target. Requests are serviced one at a time: each is accepted, executed against the array, and answered with exactly one D-channel beat.

## Interface
- `DEPTH`, 512: number of 64-bit words; power of two. Byte offset width `OW = $clog2(DEPTH)+3`.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bus`  `tilelink.slave`  —  A channel in: `a_valid`, `a_opcode[2:0]`, `a_param[2:0]`, `a_size`, `a_source[3:0]`, `a_address[63:0]`, `a_mask[7:0]`, `a_data[63:0]`; out: `a_ready`. D channel out: `d_valid`, `d_opcode`, `d_size`, `d_source`, `d_data[63:0]`; in: `d_ready`.

## Operation
- Supported opcodes, encodings from `isa.vh`: `TL_GET`, `TL_PUT_F`, `TL_ARITH_DATA`, `TL_LOGIC_DATA`. Any other opcode is treated as `TL_GET`.
- Size is `1 << a_size`, in bytes, from 1 to 8. Offset is `a_address[OW-1:0]`; higher bits are ignored, so the address space wraps modulo `DEPTH*8`. The low `a_size` offset bits are ignored, so misaligned requests hit the naturally aligned container.
- `a_data` and `d_data` are LSB-justified. Bytes beyond the size are don't-care on A and zero on D.
- `a_mask` is ignored. The written lanes are derived from the size and the offset.
- Put: writes the addressed bytes. Response is `TL_ACCESS_ACK` with `d_data=0`.
- Get: response is `TL_ACCESS_ACK_DATA` carrying the addressed bytes, zero-extended.
- AMO: the operand is `a_data` truncated to the size. The old memory value is returned as `TL_ACCESS_ACK_DATA`, and the result is written back.
  - Arithmetic `a_param`: MIN=0, MAX=1, MINU=2, MAXU=3, ADD=4. Signed compares use the sign bit of the access size. ADD wraps at the access size.
  - Logical `a_param`: XOR=0, OR=1, AND=2, SWAP=3.
  - Other param values write memory back unchanged.
- `d_size` and `d_source` echo the captured `a_size` and `a_source`.

## Timing
- FSM states:
  - IDLE: `a_ready=1`.
  - READ: synchronous array read in flight.
  - MODIFY: ALU result written back.
  - RESP: `d_valid=1`.
- Transitions on an accept (`a_valid && a_ready`):
  - Put: IDLE→RESP; the write happens on the accept edge.
  - Get: IDLE→READ→RESP.
  - AMO: IDLE→READ→MODIFY→RESP.
- Latency from accept edge to first `d_valid` cycle: Put 1, Get 2, AMO 3.
- RESP holds `d_valid` and all D fields stable until `d_ready` is sampled high. The state then goes to IDLE, and `a_ready` rises the following cycle. No back-to-back accept happens in the cycle `d_ready` handshakes.
- A fields are captured at accept. Changes on A after acceptance have no effect.
- `a_ready` is 0 in every non-IDLE state. This gives at most one outstanding request, with no overlap.
- Reset values (asynchronous): state IDLE, `a_ready=0` while `rst_n=0` and 1 after deassertion.
- Also at reset: `d_valid=0`, `d_opcode=0`, `d_size=0`, `d_source=0`, `d_data=0`, all capture registers 0.
- Array contents are not reset.
- Reset mid-operation aborts the transaction with no response. A partially completed AMO leaves memory either fully old or fully updated, because the write occurs only in MODIFY.
- `d_ready` held low: RESP persists indefinitely and no further requests are accepted.

## Structure
- Opcode and param encodings stay in `isa.vh`, shared with masters.
- FSM state enum and the lane-select/extract helper functions go in package `tl_scratchpad_pkg`.
- One combinational sub-module, `tl_amo_alu`:
  - inputs: opcode, param, size, old value, operand (all LSB-justified);
  - output: new value.
- Array: `reg [63:0] mem[DEPTH]` with per-byte write enables, inferable as single-port SRAM.

## Test plan
- Put 8 bytes `0x0706050403020100` @0x400, then Get 8 @0x400:
  - Put ack arrives 1 cycle after accept;
  - Get returns `0x0706050403020100` 2 cycles after accept.
- Byte puts `0xa8`..`0xaf` @0x418..0x41f, then:
  - Get 8 @0x418 → `0xafaeadacabaaa9a8`;
  - Get 2 @0x41a → `0xabaa`;
  - Get 1 @0x41d → `0xad`.
- ADD with 1, size 8, on @0x400 holding `0x0706050403020100`:
  - D returns old value `0x0706050403020100` 3 cycles after accept;
  - subsequent Get 8 returns `0x0706050403020101`.
- 32-bit MIN with `0xffffffff` (-1) on @0x408 holding `0x00000005`: returns `5`, memory becomes `0xffffffff`, upper word untouched. MINU with the same operand leaves `5`.
- `d_ready` held low 10 cycles during a Get response:
  - `d_valid`/`d_data` stay stable and `a_ready` stays 0;
  - a second `a_valid` is not accepted until 1 cycle after `d_ready` rises.
- Assert `rst_n` low during AMO READ state: `d_valid`=0 immediately and `a_ready`=0. After release, a Get on the AMO address returns the unmodified value.
